// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32 pipeline slice: ALU operation codes,
// forwarding mux selects, branch funct3 codes and the iterative
// multiplier state encoding.
package riscv_pkg;

  // ALU operation codes (ALUControlE)
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  localparam logic [3:0] ALU_SLTU  = 4'b0110;
  localparam logic [3:0] ALU_SLL   = 4'b0111;
  localparam logic [3:0] ALU_SRL   = 4'b1000;
  localparam logic [3:0] ALU_SRA   = 4'b1001;
  localparam logic [3:0] ALU_MUL   = 4'b1010;
  localparam logic [3:0] ALU_MULHU = 4'b1011;
  localparam logic [3:0] ALU_PASSB = 4'b1100;

  // Forwarding selects; 2'b11 falls back to the register file value
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // Branch conditions (Funct3E)
  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_BUSY = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_t;

endpackage

// File: rtl/execute_stage_mul_iter.sv
// mul_iter: radix-2 shift-add multiplier, one multiplier bit per cycle.
// Operands are captured once on start in IDLE, so upstream changes while
// busy have no effect. The product is valid while done is high.
// Optional feature macro: EXEC_MULH_EN widens the accumulator to 2*XLEN
// and lets hi_sel return the upper half of the product.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        multiply request (sampled in IDLE)
//   a, b         multiplicand / multiplier
//   hi_sel       select upper product half (EXEC_MULH_EN only)
//   busy         start-in-IDLE or iterating
//   done         product valid
//   product      XLEN-bit result
module mul_iter
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MUL_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            hi_sel,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] product
);

`ifdef EXEC_MULH_EN
  localparam int unsigned ACC_W = 2 * XLEN;
`else
  localparam int unsigned ACC_W = XLEN;
`endif
  localparam int unsigned CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  mul_state_t       state_q, state_d;
  logic [ACC_W-1:0] mcand_q;
  logic [ACC_W-1:0] acc_q;
  logic [XLEN-1:0]  mplier_q;
  logic [CNT_W-1:0] cnt_q;
  logic             last_iter;

  assign last_iter = (cnt_q == CNT_W'(MUL_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MUL_IDLE: if (start) state_d = MUL_BUSY;
      MUL_BUSY: if (last_iter) state_d = MUL_DONE;
      MUL_DONE: state_d = MUL_IDLE;
      default:  state_d = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MUL_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      unique case (state_q)
        MUL_IDLE: begin
          if (start) begin
            mcand_q  <= ACC_W'(a);
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= '0;
          end
        end
        MUL_BUSY: begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q == MUL_BUSY) || ((state_q == MUL_IDLE) && start);
  assign done = (state_q == MUL_DONE);

`ifdef EXEC_MULH_EN
  logic hi_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= 1'b0;
    end else if ((state_q == MUL_IDLE) && start) begin
      hi_q <= hi_sel;
    end
  end

  assign product = hi_q ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
`else
  logic unused_hi_sel;
  assign unused_hi_sel = hi_sel;
  assign product       = acc_q;
`endif

endmodule

// File: rtl/execute_stage.sv
// execute_stage: EX stage of the 5-stage RV32 pipeline. Forwarding muxes,
// ALU, branch/jump resolution, iterative multiplier and the EX/MEM register.
// Optional feature macro: EXEC_MULH_EN enables MULHU (code 1011) through
// the multiplier; otherwise 1011 is an ordinary op that returns 0.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   *E inputs                     decode/execute register contents
//   ForwardAE/BE, ResultW         forwarding selects and writeback value
//   PCSrcE, PCTargetE             fetch redirect (combinational)
//   StallReqE                     multiplier busy, stalls F/D/E
//   *M outputs                    EX/MEM register
module execute_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MUL_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic            JumpE,
  input  logic            BranchE,
  input  logic            ALUSrcE,
  input  logic            ALUSrcASelE,
  input  logic            JalrE,
  input  logic [1:0]      ResultSrcE,
  input  logic [3:0]      ALUControlE,
  input  logic [2:0]      Funct3E,
  input  logic [XLEN-1:0] RD1E,
  input  logic [XLEN-1:0] RD2E,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] ImmExtE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [4:0]      RdE,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            StallReqE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic [1:0]      ResultSrcM,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [4:0]      RdM
);

  localparam int unsigned SH_W = $clog2(XLEN);

  logic [XLEN-1:0] src_af, src_a, write_data_e, src_b;
  logic [XLEN-1:0] alu_result, jalr_sum;
  logic            branch_cond;
  logic            is_mul, hi_sel, mul_busy, mul_done;
  logic [XLEN-1:0] mul_product;

  // Forwarding muxes
  always_comb begin
    unique case (ForwardAE)
      FWD_W:   src_af = ResultW;
      FWD_M:   src_af = ALUResultM;
      default: src_af = RD1E;
    endcase
    unique case (ForwardBE)
      FWD_W:   write_data_e = ResultW;
      FWD_M:   write_data_e = ALUResultM;
      default: write_data_e = RD2E;
    endcase
  end

  assign src_a = ALUSrcASelE ? PCE : src_af;
  assign src_b = ALUSrcE ? ImmExtE : write_data_e;

  // ALU; multiply codes are served by mul_iter and return 0 here
  always_comb begin
    alu_result = '0;
    unique case (ALUControlE)
      ALU_ADD:   alu_result = src_a + src_b;
      ALU_SUB:   alu_result = src_a - src_b;
      ALU_AND:   alu_result = src_a & src_b;
      ALU_OR:    alu_result = src_a | src_b;
      ALU_XOR:   alu_result = src_a ^ src_b;
      ALU_SLT:   alu_result = XLEN'($signed(src_a) < $signed(src_b));
      ALU_SLTU:  alu_result = XLEN'(src_a < src_b);
      ALU_SLL:   alu_result = src_a << src_b[SH_W-1:0];
      ALU_SRL:   alu_result = src_a >> src_b[SH_W-1:0];
      ALU_SRA:   alu_result = $unsigned($signed(src_a) >>> src_b[SH_W-1:0]);
      ALU_PASSB: alu_result = src_b;
      default:   alu_result = '0;
    endcase
  end

  // Branch resolution compares the forwarded register values, not SrcA/SrcB
  always_comb begin
    branch_cond = 1'b0;
    unique case (Funct3E)
      BR_BEQ:  branch_cond = (src_af == write_data_e);
      BR_BNE:  branch_cond = (src_af != write_data_e);
      BR_BLT:  branch_cond = ($signed(src_af) <  $signed(write_data_e));
      BR_BGE:  branch_cond = ($signed(src_af) >= $signed(write_data_e));
      BR_BLTU: branch_cond = (src_af <  write_data_e);
      BR_BGEU: branch_cond = (src_af >= write_data_e);
      default: branch_cond = 1'b0;
    endcase
  end

  assign jalr_sum  = src_af + ImmExtE;
  assign PCSrcE    = JumpE | (BranchE & branch_cond);
  assign PCTargetE = JalrE ? {jalr_sum[XLEN-1:1], 1'b0} : (PCE + ImmExtE);

`ifdef EXEC_MULH_EN
  assign is_mul = (ALUControlE == ALU_MUL) || (ALUControlE == ALU_MULHU);
  assign hi_sel = (ALUControlE == ALU_MULHU);
`else
  assign is_mul = (ALUControlE == ALU_MUL);
  assign hi_sel = 1'b0;
`endif

  mul_iter #(
    .XLEN       (XLEN),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (is_mul),
    .a       (src_a),
    .b       (src_b),
    .hi_sel  (hi_sel),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Gated with rst_n so the stall request falls with reset even while the
  // multiply opcode is still presented on the inputs.
  assign StallReqE = rst_n & mul_busy;

  // EX/MEM register: bubble the controls while stalled, hold the data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= '0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
      RdM        <= '0;
    end else if (StallReqE) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= '0;
    end else begin
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
      ResultSrcM <= ResultSrcE;
      ALUResultM <= (is_mul && mul_done) ? mul_product : alu_result;
      WriteDataM <= write_data_e;
      PCPlus4M   <= PCPlus4E;
      RdM        <= RdE;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ALUSrcASelE, JalrE;
  logic [1:0]  ResultSrcE;
  logic [3:0]  ALUControlE;
  logic [2:0]  Funct3E;
  logic [31:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
  logic [4:0]  RdE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] ResultW;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        StallReqE;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned nstall;

  always #5 clk = ~clk;

  execute_stage #(.XLEN(32), .MUL_CYCLES(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
    .ALUSrcE(ALUSrcE), .ALUSrcASelE(ALUSrcASelE), .JalrE(JalrE),
    .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .Funct3E(Funct3E),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E),
    .RdE(RdE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallReqE(StallReqE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic alu_op(input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    ALUControlE = op;
    RD1E = a;
    RD2E = b;
    tick();
    check(tag, ALUResultM, exp);
  endtask

  // Counts cycles with StallReqE high (bounded); checks the bubble each cycle.
  // With toggle set, the forwarding inputs are disturbed during BUSY.
  task automatic run_mul(input bit toggle, output int unsigned n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (StallReqE !== 1'b1) break;
      n++;
      check("mul_bubble_regwrite", 32'(RegWriteM), 32'd0);
      if (toggle && i >= 1) begin
        ForwardAE = FWD_W;
        ForwardBE = FWD_W;
        ResultW   = ~ResultW;
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    RegWriteE = 0; MemWriteE = 0; JumpE = 0; BranchE = 0; ALUSrcE = 0;
    ALUSrcASelE = 0; JalrE = 0; ResultSrcE = 2'b00; ALUControlE = ALU_ADD;
    Funct3E = 3'b010; RD1E = '0; RD2E = '0; PCE = '0; ImmExtE = '0; PCPlus4E = '0;
    RdE = '0; ForwardAE = FWD_RF; ForwardBE = FWD_RF; ResultW = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_regwrite", 32'(RegWriteM), 32'd0);
    check("rst_aluresult", ALUResultM, 32'd0);
    check("rst_rd", 32'(RdM), 32'd0);
    check("rst_stall", 32'(StallReqE), 32'd0);
    #2 rst_n = 1'b1;

    // Seed ALUResultM = 100 via PASSB of the immediate
    RegWriteE = 1; RdE = 5'd3; ALUSrcE = 1; ImmExtE = 32'd100; ALUControlE = ALU_PASSB;
    tick();
    check("passb_imm", ALUResultM, 32'd100);

    // Forward A from M: 100 + 7
    ALUSrcE = 0; ALUControlE = ALU_ADD; RD1E = 32'd5; RD2E = 32'd7; ForwardAE = FWD_M;
    RdE = 5'd4; PCPlus4E = 32'h44;
    tick();
    check("fwd_m_add", ALUResultM, 32'd107);
    check("fwd_m_rd", 32'(RdM), 32'd4);
    check("fwd_m_regwrite", 32'(RegWriteM), 32'd1);
    check("fwd_m_pcplus4", PCPlus4M, 32'h44);

    // Forward B from W: 5 + 1, and store data follows the forwarded value
    ForwardAE = FWD_RF; ForwardBE = FWD_W; ResultW = 32'd1;
    tick();
    check("fwd_w_add", ALUResultM, 32'd6);
    check("fwd_w_wdata", WriteDataM, 32'd1);
    ForwardBE = FWD_RF;

    // ALU operations
    alu_op("sub",    ALU_SUB,   32'd5,         32'd7,      32'hFFFF_FFFE);
    alu_op("and",    ALU_AND,   32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
    alu_op("or",     ALU_OR,    32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0);
    alu_op("xor",    ALU_XOR,   32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0);
    alu_op("slt",    ALU_SLT,   32'hFFFF_FFFF, 32'd1,      32'd1);
    alu_op("sltu",   ALU_SLTU,  32'hFFFF_FFFF, 32'd1,      32'd0);
    alu_op("sll31",  ALU_SLL,   32'd1,         32'h3F,     32'h8000_0000);
    alu_op("srl",    ALU_SRL,   32'h8000_0000, 32'd4,      32'h0800_0000);
    alu_op("sra",    ALU_SRA,   32'h8000_0000, 32'd4,      32'hF800_0000);
    alu_op("passb",  ALU_PASSB, 32'd9,         32'h55,     32'h55);
    alu_op("undef",  4'b1101,   32'd5,         32'd7,      32'd0);
    alu_op("wrap",   ALU_ADD,   32'hFFFF_FFFF, 32'd2,      32'd1);

    // SrcA = PC, SrcB = immediate (AUIPC-style)
    ALUSrcASelE = 1; ALUSrcE = 1; PCE = 32'h200; ImmExtE = 32'd4; ALUControlE = ALU_ADD;
    tick();
    check("auipc", ALUResultM, 32'h204);
    ALUSrcASelE = 0; ALUSrcE = 0;

    // Branch resolution (combinational)
    RegWriteE = 0; BranchE = 1; RD1E = 32'hFFFF_FFFF; RD2E = 32'd1;
    Funct3E = BR_BLT;  #1 check("blt_taken", 32'(PCSrcE), 32'd1);
    Funct3E = BR_BLTU; #1 check("bltu_not", 32'(PCSrcE), 32'd0);
    Funct3E = BR_BGEU; #1 check("bgeu_taken", 32'(PCSrcE), 32'd1);
    Funct3E = BR_BNE;  #1 check("bne_taken", 32'(PCSrcE), 32'd1);
    Funct3E = BR_BEQ;  #1 check("beq_not", 32'(PCSrcE), 32'd0);
    Funct3E = 3'b010;  #1 check("f3_010_never", 32'(PCSrcE), 32'd0);
    PCE = 32'h100; ImmExtE = 32'h20;
    #1 check("br_target", PCTargetE, 32'h120);
    BranchE = 0; JumpE = 1; JalrE = 1; RD1E = 32'h1003; ImmExtE = 32'd4;
    #1 check("jalr_target", PCTargetE, 32'h1006);
    check("jump_taken", 32'(PCSrcE), 32'd1);
    JumpE = 0; JalrE = 0;
    tick();

    // MUL with forwarding disturbed during BUSY
    RegWriteE = 1; RdE = 5'd5; ALUControlE = ALU_MUL;
    RD1E = 32'h1234_5678; RD2E = 32'h10; ResultW = 32'hA5A5_A5A5;
    #1;
    run_mul(1'b1, nstall);
    check("mul_stall_cycles", nstall, 32'd33);
    check("mul_done_bubble", 32'(RegWriteM), 32'd0);
    tick();
    check("mul_product", ALUResultM, 32'h2345_6780);
    check("mul_regwrite", 32'(RegWriteM), 32'd1);
    check("mul_rd", 32'(RdM), 32'd5);

    // Second MUL, reset asynchronously at BUSY count 10
    ForwardAE = FWD_RF; ForwardBE = FWD_RF; RD1E = 32'd3; RD2E = 32'd5;
    #1 check("mul2_start_stall", 32'(StallReqE), 32'd1);
    repeat (11) tick();
    check("mul2_busy_stall", 32'(StallReqE), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_stall", 32'(StallReqE), 32'd0);
    check("arst_regwrite", 32'(RegWriteM), 32'd0);
    check("arst_aluresult", ALUResultM, 32'd0);
    check("arst_rd", 32'(RdM), 32'd0);
    check("arst_pcplus4", PCPlus4M, 32'd0);
    check("arst_wdata", WriteDataM, 32'd0);
    ALUControlE = ALU_ADD; RD1E = 32'd20; RD2E = 32'd22; MemWriteE = 1;
    ResultSrcE = 2'b01; PCPlus4E = 32'h104; RdE = 5'd7;
    @(negedge clk) rst_n = 1'b1;
    #1 check("post_rst_stall", 32'(StallReqE), 32'd0);
    tick();
    check("post_rst_add", ALUResultM, 32'd42);
    check("post_rst_regwrite", 32'(RegWriteM), 32'd1);
    check("post_rst_memwrite", 32'(MemWriteM), 32'd1);
    check("post_rst_resultsrc", 32'(ResultSrcM), 32'd1);
    check("post_rst_pcplus4", PCPlus4M, 32'h104);
    check("post_rst_wdata", WriteDataM, 32'd22);

    // MULHU
    MemWriteE = 0; ResultSrcE = 2'b00; RdE = 5'd9; ALUControlE = ALU_MULHU;
    RD1E = 32'hFFFF_FFFF; RD2E = 32'hFFFF_FFFF;
    #1;
`ifdef EXEC_MULH_EN
    run_mul(1'b0, nstall);
    check("mulhu_stall_cycles", nstall, 32'd33);
    tick();
    check("mulhu_product", ALUResultM, 32'hFFFF_FFFE);
`else
    check("mulhu_no_stall", 32'(StallReqE), 32'd0);
    tick();
    check("mulhu_zero", ALUResultM, 32'd0);
`endif
    check("mulhu_regwrite", 32'(RegWriteM), 32'd1);
    ALUControlE = ALU_ADD;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute stage of the 5-stage RV32 pipeline. It consumes the decode/execute register outputs (*E signals) and produces branch/jump redirect signals for fetch.
- It contains the forwarding muxes, the ALU, branch resolution and an iterative 32-cycle multiplier.
- It owns the EX/MEM pipeline register (*M outputs) that feeds the memory stage.

Parameters:
- XLEN, 32, datapath width.
- MUL_CYCLES, 32, multiplier iterations (must equal XLEN).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ALUSrcASelE, JalrE  in  1 each  execute controls
- ResultSrcE  in  2  result select, passed through to memory stage
- ALUControlE  in  4  ALU operation
- Funct3E  in  3  branch condition
- RD1E, RD2E, PCE, ImmExtE, PCPlus4E  in  XLEN each  operands
- RdE  in  5  destination register
- ForwardAE, ForwardBE  in  2 each  00=RDxE, 01=ResultW, 10=ALUResultM, 11=RDxE
- ResultW  in  XLEN  writeback value
- PCSrcE  out  1  redirect fetch (combinational)
- PCTargetE  out  XLEN  redirect target (combinational)
- StallReqE  out  1  multiplier busy; hazard unit stalls F/D/E
- RegWriteM, MemWriteM  out  1 each
- ResultSrcM  out  2
- ALUResultM, WriteDataM, PCPlus4M  out  XLEN each
- RdM  out  5

Behaviour:
- Operand selection:
  - SrcAf = forward mux on RD1E (per ForwardAE). SrcA = ALUSrcASelE ? PCE : SrcAf.
  - WriteDataE = forward mux on RD2E (per ForwardBE). SrcB = ALUSrcE ? ImmExtE : WriteDataE.
- ALU encoding:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT (signed), 0110 SLTU.
  - 0111 SLL, 1000 SRL, 1001 SRA; shifts use SrcB[4:0].
  - 1010 MUL (low XLEN bits), 1011 MULHU (see optional feature), 1100 pass SrcB.
  - Other codes return 0. All arithmetic is modulo 2^XLEN.
- Branch resolution, combinational, on SrcAf vs WriteDataE:
  - Funct3E 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU; 010/011 never taken.
  - PCSrcE = JumpE | (BranchE & cond).
  - PCTargetE = JalrE ? ((SrcAf+ImmExtE) & ~1) : (PCE+ImmExtE).
- Multiplier FSM, states IDLE, BUSY, DONE:
  - IDLE: on isMul (ALUControlE==1010 or 1011), capture SrcA into multiplicand and SrcB into multiplier, clear accumulator, set count=0, go BUSY.
  - BUSY: radix-2 shift-add, one bit per cycle. Go DONE when count==MUL_CYCLES-1.
  - DONE: product is valid; EX/MEM latches it; always returns to IDLE next cycle.
  - StallReqE = (IDLE & isMul) | BUSY. It is low in DONE.
  - MUL latency: 34 cycles in E; StallReqE is high for 33 of them.
  - Operands are captured once at start, so later changes on ResultW/ALUResultM during the stall do not affect the product.
- EX/MEM register (posedge clk):
  - When StallReqE=1: inserts a bubble (RegWriteM=0, MemWriteM=0, ResultSrcM=00). Other *M fields hold.
  - Otherwise latches RegWriteE, ResultSrcE, MemWriteE, RdE, PCPlus4E and WriteDataE. ALUResultM = isMul ? product : ALU result.
  - Flushing E (a bubble from the decode/execute register) arrives as zero controls; no separate M flush exists.
- Reset (asynchronous, any cycle including mid-multiply):
  - All *M outputs = 0; FSM to IDLE; count, accumulator and operands = 0.
  - StallReqE drops immediately with reset.
- Simultaneous events: PCSrcE is not gated by StallReqE. A MUL instruction never has Jump/Branch set.

Optional Feature:
- EXEC_MULH_EN defined:
  - Accumulator is 2*XLEN bits.
  - 1011 (MULHU) returns the unsigned upper XLEN bits and uses the same FSM and latency.
- EXEC_MULH_EN undefined:
  - Accumulator is XLEN bits.
  - 1011 is not treated as a multiply: no stall, result 0.

Decomposition:
- Shared package riscv_pkg holds:
  - ALU op constants (ALU_ADD ... ALU_PASSB).
  - Forward select constants (FWD_RF, FWD_W, FWD_M).
  - Branch funct3 constants.
  - The FSM state enum (MUL_IDLE, MUL_BUSY, MUL_DONE).
- One natural sub-module: mul_iter (FSM + shift-add datapath). Interface: start, a, b, hi_sel → busy, done, product.

Test Plan:
- Forwarding and ALU: RD1E=5, RD2E=7, ALU ADD, ForwardAE=10 with ALUResultM=100 → ALUResultM=107 next cycle. With ForwardBE=01 and ResultW=1 (ForwardAE back to 00) → 6.
- Branches: BranchE=1, Funct3E=100, SrcAf=0xFFFFFFFF, WriteDataE=1 → PCSrcE=1. Funct3E=110 with the same operands → PCSrcE=0. JALR: SrcAf=0x1003, Imm=4 → PCTargetE=0x1006.
- MUL: SrcA=0x12345678, SrcB=0x10 → StallReqE high exactly 33 cycles, RegWriteM=0 during them, then ALUResultM=0x23456780 with RegWriteM=1.
- Stall/forward change during MUL: toggle ResultW each cycle during BUSY → product unchanged.
- Async reset at BUSY count 10 → StallReqE=0 and all *M outputs 0 before the next edge. After release, a following ADD completes in 1 cycle.
- EXEC_MULH_EN: MULHU with 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. Without the macro, the same op → no stall, result 0.
